// File: rtl/c0_5_tracker_pkg.sv
// Shared types and helpers for the mod-5 counter tracker.
package c5_pkg;

  localparam int unsigned C5_MOD = 5;
  localparam logic [2:0]  C5_MAX = 3'(C5_MOD - 1);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } c5_state_t;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    UP      = 3'd1,
    DOWN    = 3'd2,
    WRAP_UP = 3'd3,
    WRAP_DN = 3'd4,
    BAD     = 3'd5
  } c5_step_t;

  function automatic logic [2:0] inc5(input logic [2:0] v);
    return (v == C5_MAX) ? 3'd0 : v + 3'd1;
  endfunction

  function automatic logic [2:0] dec5(input logic [2:0] v);
    return (v == 3'd0) ? C5_MAX : v - 3'd1;
  endfunction

endpackage

// File: rtl/c0_5_tracker_if.sv
// Counter-side inputs and tracker outputs of c0_5_tracker.
interface c0_5_tracker_if #(
  parameter int unsigned HI_W = 4
);
  logic            enable;
  logic            reverse;
  logic [2:0]      q;
  logic            clear;
  logic [2:0]      lo;
  logic [HI_W-1:0] hi;
  logic            carry;
  logic            borrow;
  logic            illegal;

  modport master (
    output enable, reverse, q, clear,
    input  lo, hi, carry, borrow, illegal
  );

  modport slave (
    input  enable, reverse, q, clear,
    output lo, hi, carry, borrow, illegal
  );
endinterface

// File: rtl/c0_5_tracker_step_classify.sv
// Combinational classification of one mod-5 step from prev to q.
module step_classify_5
  import c5_pkg::*;
(
  input  logic [2:0] i_prev,
  input  logic [2:0] i_q,
  output c5_step_t   o_step
);

  always_comb begin
    o_step = BAD;
    if (i_q <= C5_MAX && i_prev <= C5_MAX) begin
      if (i_q == i_prev)
        o_step = HOLD;
      else if (i_q == inc5(i_prev))
        o_step = (i_prev == C5_MAX) ? WRAP_UP : UP;
      else if (i_q == dec5(i_prev))
        o_step = (i_prev == 3'd0) ? WRAP_DN : DOWN;
    end
  end

endmodule

// File: rtl/c0_5_tracker.sv
// Mod-5 counter monitor: wrap accumulator, carry/borrow pulses, fault flag.
// Optional macro C5_DIR_CHECK_EN adds enable/direction consistency checks.
module c0_5_tracker
  import c5_pkg::*;
#(
  parameter int unsigned HI_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  c0_5_tracker_if.slave bus
);

  c5_state_t       r_state;
  logic [2:0]      r_prev;
  logic [HI_W-1:0] r_hi;
  logic            r_carry;
  logic            r_borrow;
  c5_step_t        w_step;
  logic            w_dir_bad;
  logic            w_bad;

  step_classify_5 u_classify (
    .i_prev (r_prev),
    .i_q    (bus.q),
    .o_step (w_step)
  );

`ifdef C5_DIR_CHECK_EN
  logic r_enable_d;
  logic r_reverse_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable_d  <= 1'b0;
      r_reverse_d <= 1'b0;
    end else begin
      r_enable_d  <= bus.enable;
      r_reverse_d <= bus.reverse;
    end
  end

  // A running counter must move every cycle; a stopped one must not move.
  always_comb begin
    w_dir_bad = 1'b0;
    if (!r_enable_d && bus.q != r_prev)                 w_dir_bad = 1'b1;
    if (r_enable_d && bus.q == r_prev)                  w_dir_bad = 1'b1;
    if ((w_step == UP || w_step == WRAP_UP) && r_reverse_d)
      w_dir_bad = 1'b1;
    if ((w_step == DOWN || w_step == WRAP_DN) && !r_reverse_d)
      w_dir_bad = 1'b1;
  end
`else
  logic w_unused;
  assign w_unused  = bus.enable ^ bus.reverse;
  assign w_dir_bad = 1'b0;
`endif

  assign w_bad = (w_step == BAD) || w_dir_bad;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= INIT;
      r_prev   <= '0;
      r_hi     <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (bus.clear) begin
        r_state <= INIT;
        r_prev  <= '0;
        r_hi    <= '0;
      end else begin
        case (r_state)
          INIT: begin
            r_prev  <= bus.q;
            r_state <= (bus.q <= C5_MAX) ? TRACK : FAULT;
          end
          TRACK: begin
            if (w_bad) begin
              r_state <= FAULT;
            end else begin
              r_prev <= bus.q;
              if (w_step == WRAP_UP) begin
                r_hi    <= r_hi + HI_W'(1);
                r_carry <= 1'b1;
              end else if (w_step == WRAP_DN) begin
                r_hi     <= r_hi - HI_W'(1);
                r_borrow <= 1'b1;
              end
            end
          end
          FAULT:   r_state <= FAULT;
          default: r_state <= INIT;
        endcase
      end
    end
  end

  assign bus.lo      = r_prev;
  assign bus.hi      = r_hi;
  assign bus.carry   = r_carry;
  assign bus.borrow  = r_borrow;
  assign bus.illegal = (r_state == FAULT);

endmodule

// File: tb/tb_c0_5_tracker.sv
// Directed table-driven bench for c0_5_tracker (HI_W = 4).
module tb_c0_5_tracker;

`ifdef C5_DIR_CHECK_EN
  localparam bit DIR = 1'b1;
`else
  localparam bit DIR = 1'b0;
`endif

  typedef struct {
    logic       clr;
    logic       en;
    logic       rev;
    logic [2:0] q;
    logic [2:0] lo;
    logic [3:0] hi;
    logic       c;
    logic       b;
    logic       ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  vec_t tbl[$];

  c0_5_tracker_if #(.HI_W(4)) bus ();

  c0_5_tracker #(.HI_W(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] lo, input logic [3:0] hi,
                       input logic c, input logic b, input logic ill);
    n_total++;
    if (bus.lo === lo && bus.hi === hi && bus.carry === c && bus.borrow === b
        && bus.illegal === ill)
      n_pass++;
    else
      $display("FAIL %s: got lo=%0d hi=%0d carry=%b borrow=%b illegal=%b, expected lo=%0d hi=%0d carry=%b borrow=%b illegal=%b",
               name, bus.lo, bus.hi, bus.carry, bus.borrow, bus.illegal, lo, hi, c, b, ill);
  endtask

  task automatic add(input logic clr, input logic en, input logic rev, input logic [2:0] q,
                     input logic [2:0] lo, input logic [3:0] hi,
                     input logic c, input logic b, input logic ill);
    vec_t v;
    v.clr = clr; v.en = en; v.rev = rev; v.q = q;
    v.lo = lo; v.hi = hi; v.c = c; v.b = b; v.ill = ill;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic en, input logic rev, input logic [2:0] q);
    bus.clear   = clr;
    bus.enable  = en;
    bus.reverse = rev;
    bus.q       = q;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'd0);

    //   clr en rev q    lo  hi  c  b  ill
    add(0, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);  // INIT capture
    add(0, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd1, 3'd1, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd2, 3'd2, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd3, 3'd3, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd4, 3'd4, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 4'd1,  1, 0, 0);  // up-wrap
    add(0, 1, 1, 3'd1, 3'd1, 4'd1,  0, 0, 0);
    add(0, 1, 1, 3'd0, 3'd0, 4'd1,  0, 0, 0);
    add(0, 1, 1, 3'd4, 3'd4, 4'd0,  0, 1, 0);  // down-wrap
    add(0, 1, 1, 3'd3, 3'd3, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd2, 3'd2, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd1, 3'd1, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd4, 3'd4, 4'd15, 0, 1, 0);  // hi 0 -> 15
    add(0, 1, 1, 3'd3, 3'd3, 4'd15, 0, 0, 0);
    add(0, 1, 0, 3'd1, 3'd3, 4'd15, 0, 0, 1);  // 3 -> 1 jump
    add(0, 1, 0, 3'd2, 3'd3, 4'd15, 0, 0, 1);  // frozen
    add(1, 1, 0, 3'd3, 3'd0, 4'd0,  0, 0, 0);  // clear
    add(0, 0, 0, 3'd3, 3'd3, 4'd0,  0, 0, 0);  // INIT capture of 3
    add(0, 0, 0, 3'd3, 3'd3, 4'd0,  0, 0, 0);
    add(0, 0, 0, 3'd6, 3'd3, 4'd0,  0, 0, 1);  // out-of-range code
    add(1, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd1, 3'd1, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd2, 3'd2, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd3, 3'd3, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd4, 3'd4, 4'd0,  0, 0, 0);
    add(1, 1, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);  // clear beats wrap
    add(0, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd1, 3'd1, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd2, 3'd2, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd3, DIR ? 3'd2 : 3'd3, 4'd0, 0, 0, DIR);  // up while reversed
    add(1, 0, 0, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 1, 3'd0, 3'd0, 4'd0,  0, 0, 0);
    add(0, 1, 0, 3'd4, 3'd4, 4'd15, 0, 1, 0);  // back-to-back wraps
    add(0, 1, 1, 3'd0, 3'd0, 4'd0,  1, 0, 0);
    add(0, 1, 0, 3'd4, 3'd4, 4'd15, 0, 1, 0);
    add(0, 1, 0, 3'd0, 3'd0, 4'd0,  1, 0, 0);

    #12;
    check("reset_values", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].clr, tbl[i].en, tbl[i].rev, tbl[i].q);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), tbl[i].lo, tbl[i].hi, tbl[i].c, tbl[i].b, tbl[i].ill);
    end

    // Reset asserted while a 4 -> 0 wrap is presented.
    drive(1'b1, 1'b1, 1'b0, 3'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 3'd4);
    @(posedge clk); #1;
    check("pre_reset_init4", 3'd4, 4'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 3'd0);
    #2 rst_n = 1'b0;
    #1 check("async_reset_now", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_over_wrap", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'd3);
    @(posedge clk); #1;
    check("post_reset_init", 3'd3, 4'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("post_reset_hold", 3'd3, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/c0_5_tracker.md
# c0_5_tracker

Downstream monitor for the mod-5 up/down counter. Samples the counter's 3-bit output every clock, classifies each step (hold, up, down, wrap), accumulates wraps into a higher-order digit and flags illegal codes or transitions. Sits between the mod-5 counter and the display/cascade logic, turning a single mod-5 digit into a two-level count with a fault indication.

## Interface

Parameters:
- HI_W, default 4: width of the wrap accumulator `hi`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- enable  in  1  the same enable that drives the counter.
- reverse  in  1  the same direction control that drives the counter; 1 = count down.
- q  in  3  counter value Q[3:1]; legal codes 0..4.
- clear  in  1  synchronous clear of tracker state; takes priority over everything except reset.
- lo  out  3  registered copy of the last sampled q.
- hi  out  HI_W  wrap accumulator.
- carry  out  1  one-cycle pulse on an up-wrap (4 -> 0).
- borrow  out  1  one-cycle pulse on a down-wrap (0 -> 4).
- illegal  out  1  high while in FAULT.

## Operation

- State machine: INIT, TRACK, FAULT.
- Registers: prev (3 b), enable_d, reverse_d (input values from the previous cycle), hi, carry, borrow, state.
- INIT (after reset or clear): capture q into prev. q <= 4 -> TRACK, otherwise -> FAULT. No pulses; hi unchanged (already 0).
- TRACK, classify (prev, q):
  - q == prev: HOLD.
  - q == (prev+1) mod 5: UP; prev==4, q==0 is WRAP_UP: hi <= hi+1 (mod 2^HI_W), carry <= 1.
  - q == (prev+4) mod 5: DOWN; prev==0, q==4 is WRAP_DN: hi <= hi-1 (mod 2^HI_W), borrow <= 1.
  - q > 4, or any other delta: BAD -> FAULT.
  - prev <= q in all non-BAD cases.
- FAULT: illegal = 1; hi, lo, prev frozen; carry/borrow = 0. Left only through clear or reset.
- clear: state <= INIT, hi <= 0, carry/borrow <= 0, prev/lo <= 0. A clear in the same cycle as a wrap discards the wrap.
- hi wraps silently at 2^HI_W - 1 -> 0 (up) and 0 -> 2^HI_W - 1 (down).

## Timing

- Reset values: lo = 0, hi = 0, carry = 0, borrow = 0, illegal = 0, state = INIT.
- Latency: q changes at edge k; classification occurs at edge k+1; hi, lo, carry and borrow update there and are visible for the cycle after edge k+1.
- carry and borrow last exactly one cycle and are never high together.
- Back-to-back wraps, e.g. with q toggling 4/0, produce pulses on consecutive cycles.
- Reset asserted mid-operation zeroes all outputs immediately. The first edge after deassertion is an INIT capture.
- illegal rises one cycle after the offending sample and stays high until clear.

## Configuration

- Macro C5_DIR_CHECK_EN.
  - Defined: in TRACK, additionally mark BAD if:
    - q changed while enable_d == 0;
    - enable_d == 1 and q == prev;
    - UP/WRAP_UP with reverse_d == 1;
    - DOWN/WRAP_DN with reverse_d == 0.
  - Not defined: enable and reverse are ignored, and only code range and step size are checked. enable_d and reverse_d registers are not built.

## Structure

- Package c5_pkg:
  - constant C5_MOD = 5;
  - typedef enum c5_state_t {INIT, TRACK, FAULT};
  - typedef enum c5_step_t {HOLD, UP, DOWN, WRAP_UP, WRAP_DN, BAD};
  - functions inc5/dec5.
- Sub-module step_classify_5: combinational (prev, q) -> c5_step_t. The top applies the direction check and the state machine.

## Test plan

- Reset then q held 0 with enable=0 for 3 cycles -> state TRACK, hi=0, no pulses, illegal=0.
- enable=1, reverse=0, q 0,1,2,3,4,0,1 -> one carry pulse the cycle after the 4->0 sample, hi=1, lo tracks q delayed by one.
- reverse=1, q 0,4,3 from hi=0 -> borrow pulse, hi = 2^HI_W-1 (15 for HI_W=4).
- q jumps 1 -> 3, or q=6 -> illegal high next cycle and stays high; hi frozen; clear -> illegal=0, hi=0, INIT capture.
- With C5_DIR_CHECK_EN: reverse=1 but q steps 2->3 -> illegal. Without the macro, the same stimulus -> no fault.
- Reset pulled low during a wrap cycle, and clear coincident with 4->0 -> no carry, hi=0.
